// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared types and widths for the noise voice
package noise_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        HOLD,
        RELEASE
    } env_state_t;

    localparam int SMP_W  = 8;
    localparam int Y_W    = 12;
    localparam int Y_FRAC = 4;
    localparam int ENV_W  = 8;

endpackage

// File: rtl/noise_env.sv
// rtl/noise_env.sv - gate-driven linear envelope, stepping once per sample tick
module noise_env
    import noise_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_tick,
    input  logic             gate,
    input  logic [ENV_W-1:0] level,
    output logic [ENV_W-1:0] env,
    output env_state_t       state
);

    // One extra bit so that env=255 plus one still compares correctly against level
    logic [ENV_W:0] env_inc;
    assign env_inc = {1'b0, env} + (ENV_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env   <= '0;
            state <= IDLE;
        end else if (sample_tick) begin
            case (state)
                IDLE: begin
                    env <= '0;
                    if (gate) state <= ATTACK;
                end
                ATTACK: begin
                    if (!gate) begin
                        state <= RELEASE;
                    end else if (env_inc >= {1'b0, level}) begin
                        env   <= level;
                        state <= HOLD;
                    end else begin
                        env <= env_inc[ENV_W-1:0];
                    end
                end
                HOLD: begin
                    if (!gate) state <= RELEASE;
                    else       env   <= level;
                end
                RELEASE: begin
                    if (gate) begin
                        state <= ATTACK;
                    end else if (env <= ENV_W'(1)) begin
                        env   <= '0;
                        state <= IDLE;
                    end else begin
                        env <= env - ENV_W'(1);
                    end
                end
                default: begin
                    env   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/noise_shaper.sv
// rtl/noise_shaper.sv - pitched, smoothed, enveloped noise voice: resample, smooth, scale
module noise_shaper
    import noise_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_tick,
    input  logic [SMP_W-1:0] rnd,
    input  logic [ACC_W-1:0] rate,
    input  logic [2:0]       smooth,
    input  logic [ENV_W-1:0] level,
    input  logic             gate,
    output logic [SMP_W-1:0] sout,
    output logic             sout_valid
);

    logic [ACC_W-1:0]        acc;
    logic [ACC_W:0]          acc_sum;
    logic signed [SMP_W-1:0] held;
    logic [2:0]              k0;
    logic                    v0;
    logic                    v1;
    logic signed [Y_W-1:0]   y;
    logic signed [Y_W-1:0]   x;
    logic signed [Y_W:0]     diff;
    logic signed [Y_W:0]     step;
    logic signed [Y_W-1:0]   y_next;
    logic [ENV_W-1:0]        env;
    logic [ENV_W-1:0]        env1;
    env_state_t              state;
    logic [15:0]             prod;

    noise_env u_env (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .gate        (gate),
        .level       (level),
        .env         (env),
        .state       (state)
    );

    assign acc_sum = {1'b0, acc} + {1'b0, rate};

    // Difference kept at 13 bits so the arithmetic shift never loses the sign
    assign x      = {held, {Y_FRAC{1'b0}}};
    assign diff   = {x[Y_W-1], x} - {y[Y_W-1], y};
    assign step   = diff >>> k0;
    assign y_next = Y_W'({y[Y_W-1], y} + step);

    // Low 16 bits of the signed 8x9 product; the result range never needs bit 16
    assign prod = {{8{y[Y_W-1]}}, y[Y_W-1:Y_FRAC]} * {8'd0, env1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            held       <= '0;
            k0         <= '0;
            v0         <= 1'b0;
            v1         <= 1'b0;
            y          <= '0;
            env1       <= '0;
            sout       <= '0;
            sout_valid <= 1'b0;
        end else begin
            v0         <= sample_tick;
            v1         <= v0;
            sout_valid <= v1;
            if (sample_tick) begin
                acc <= acc_sum[ACC_W-1:0];
                k0  <= smooth;
                if (acc_sum[ACC_W]) held <= rnd ^ 8'h80;
            end
            // Envelope is captured alongside y so back-to-back ticks stay paired
            if (v0) begin
                y    <= y_next;
                env1 <= (state == IDLE) ? '0 : env;
            end
            if (v1) sout <= 8'(prod >> 8);
        end
    end

endmodule
